// File: rtl/draw_sequencer_param.sv
// Draw-command sequencer: steps the VGA engine through the title screens and a
// parametrised per-frame job list, with frame sync, pause and a game-over path.
module draw_sequencer_param #(
    parameter int CMD_W     = 5,
    parameter int N_LANES   = 15,
    parameter int N_LINES   = 3,
    parameter int N_SCORE   = 2,
    parameter int TITLE_CNT = 19201,
    parameter int LANE_CNT  = 32,
    parameter int LINE_CNT  = 32,
    parameter int SCORE_CNT = 300,
    parameter int BG_CNT    = 19201,
    parameter int CLEAR_CNT = 160,
    parameter int HANDSHAKE = 0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             continue_game,
    input  logic             pause,
    input  logic             frame_sync,
    input  logic             game_over,
    input  logic             draw_done,
    output logic [CMD_W-1:0] command,
    output logic [1:0]       choose,
    output logic             step_start,
    output logic             frame_done,
    output logic             busy
);

    localparam bit HS = (HANDSHAKE != 0);

    localparam int MAX_C1  = (TITLE_CNT > LANE_CNT) ? TITLE_CNT : LANE_CNT;
    localparam int MAX_C2  = (MAX_C1 > LINE_CNT) ? MAX_C1 : LINE_CNT;
    localparam int MAX_C3  = (MAX_C2 > SCORE_CNT) ? MAX_C2 : SCORE_CNT;
    localparam int MAX_C4  = (MAX_C3 > BG_CNT) ? MAX_C3 : BG_CNT;
    localparam int MAX_CNT = (MAX_C4 > CLEAR_CNT) ? MAX_C4 : CLEAR_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam int MAX_I1  = (N_LANES > N_LINES) ? N_LANES : N_LINES;
    localparam int MAX_IDX = (MAX_I1 > N_SCORE) ? MAX_I1 : N_SCORE;
    localparam int IDX_W   = $clog2(MAX_IDX + 1);

    localparam logic [IDX_W-1:0] LAST_LANE  = IDX_W'(N_LANES - 1);
    localparam logic [IDX_W-1:0] LAST_LINE  = IDX_W'((N_LINES > 0) ? N_LINES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_SCORE = IDX_W'((N_SCORE > 0) ? N_SCORE - 1 : 0);

    // Job codes are laid out contiguously: titles, lanes, lines, score digits, then the fixed jobs.
    localparam logic [CMD_W-1:0] LANE_BASE  = CMD_W'(2);
    localparam logic [CMD_W-1:0] LINE_BASE  = CMD_W'(2 + N_LANES);
    localparam logic [CMD_W-1:0] SCORE_BASE = CMD_W'(2 + N_LANES + N_LINES);
    localparam logic [CMD_W-1:0] CODE_BG    = CMD_W'(2 + N_LANES + N_LINES + N_SCORE);
    localparam logic [CMD_W-1:0] CODE_CLEAR = CMD_W'(3 + N_LANES + N_LINES + N_SCORE);
    localparam logic [CMD_W-1:0] CODE_FINAL = CMD_W'(4 + N_LANES + N_LINES + N_SCORE);
    localparam logic [CMD_W-1:0] CODE_STOP  = CMD_W'(5 + N_LANES + N_LINES + N_SCORE);
    localparam logic [CMD_W-1:0] CODE_WAIT  = CMD_W'(6 + N_LANES + N_LINES + N_SCORE);

    typedef enum logic [3:0] {
        K_TITLE_A,
        K_TITLE_B,
        K_LANE,
        K_LINE,
        K_SCORE,
        K_BG,
        K_CLEAR,
        K_WAIT,
        K_FINAL,
        K_STOP
    } kind_t;

    kind_t            kind_q, kind_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_last;
    logic             first_q;
    logic             go_q;
    logic             go_eff;
    logic             drawing;
    logic             counting;
    logic             timed_end;
    logic             step_end;
    logic             adv;

    assign go_eff = go_q | game_over;

    // Step-end detection: title is always counted; drawing jobs are counted or handshaken.
    always_comb begin
        cnt_last = '0;
        drawing  = 1'b0;
        case (kind_q)
            K_TITLE_A, K_TITLE_B: cnt_last = CNT_W'(TITLE_CNT - 1);
            K_LANE:  begin cnt_last = CNT_W'(LANE_CNT - 1);  drawing = 1'b1; end
            K_LINE:  begin cnt_last = CNT_W'(LINE_CNT - 1);  drawing = 1'b1; end
            K_SCORE: begin cnt_last = CNT_W'(SCORE_CNT - 1); drawing = 1'b1; end
            K_BG:    begin cnt_last = CNT_W'(BG_CNT - 1);    drawing = 1'b1; end
            K_CLEAR: begin cnt_last = CNT_W'(CLEAR_CNT - 1); drawing = 1'b1; end
            K_FINAL: begin cnt_last = CNT_W'(BG_CNT - 1);    drawing = 1'b1; end
            default: begin cnt_last = '0;                    drawing = 1'b0; end
        endcase
    end

    assign timed_end = (cnt_q == cnt_last);
    assign counting  = (kind_q == K_TITLE_A) || (kind_q == K_TITLE_B) || (drawing && !HS);

    always_comb begin
        step_end = 1'b0;
        if (kind_q == K_TITLE_A || kind_q == K_TITLE_B) begin
            step_end = timed_end;
        end else if (drawing) begin
            // draw_done in a step's first cycle belongs to the previous job, so it is ignored.
            step_end = HS ? (draw_done && !first_q) : timed_end;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!reset) begin
            kind_q  <= K_TITLE_A;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            go_q    <= 1'b0;
        end else begin
            kind_q  <= kind_d;
            idx_q   <= idx_d;
            first_q <= adv;
            cnt_q   <= (adv || !counting) ? '0 : cnt_q + CNT_W'(1);
            if (game_over && kind_q != K_TITLE_A && kind_q != K_TITLE_B) begin
                go_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        kind_d = kind_q;
        idx_d  = idx_q;
        case (kind_q)
            K_TITLE_A: begin
                if (continue_game) begin
                    kind_d = K_LANE;
                    idx_d  = '0;
                end else if (step_end) begin
                    kind_d = K_TITLE_B;
                end
            end
            K_TITLE_B: begin
                if (continue_game) begin
                    kind_d = K_LANE;
                    idx_d  = '0;
                end else if (step_end) begin
                    kind_d = K_TITLE_A;
                end
            end
            K_LANE: begin
                if (step_end) begin
                    if (idx_q != LAST_LANE) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        if (N_LINES > 0)      kind_d = K_LINE;
                        else if (N_SCORE > 0) kind_d = K_SCORE;
                        else                  kind_d = K_BG;
                    end
                end
            end
            K_LINE: begin
                if (step_end) begin
                    if (idx_q != LAST_LINE) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        if (N_SCORE > 0) kind_d = K_SCORE;
                        else             kind_d = K_BG;
                    end
                end
            end
            K_SCORE: begin
                if (step_end) begin
                    if (idx_q != LAST_SCORE) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d  = '0;
                        kind_d = K_BG;
                    end
                end
            end
            K_BG: begin
                if (step_end) kind_d = K_CLEAR;
            end
            K_CLEAR: begin
                if (step_end) kind_d = go_eff ? K_FINAL : K_WAIT;
            end
            K_WAIT: begin
                // Game over beats a simultaneous frame_sync.
                if (go_eff) begin
                    kind_d = K_FINAL;
                end else if (frame_sync && !pause) begin
                    kind_d = K_LANE;
                    idx_d  = '0;
                end
            end
            K_FINAL: begin
                if (step_end) kind_d = K_STOP;
            end
            K_STOP: begin
                kind_d = K_STOP;
            end
            default: begin
                kind_d = K_TITLE_A;
                idx_d  = '0;
            end
        endcase
    end

    assign adv = (kind_d != kind_q) || (idx_d != idx_q);

    // Output decode from registered state
    always_comb begin
        command = '0;
        choose  = 2'b10;
        busy    = drawing;
        case (kind_q)
            K_TITLE_A: begin command = '0;        choose = 2'b00; end
            K_TITLE_B: begin command = CMD_W'(1); choose = 2'b01; end
            K_LANE:    command = LANE_BASE + CMD_W'(idx_q);
            K_LINE:    command = LINE_BASE + CMD_W'(idx_q);
            K_SCORE:   command = SCORE_BASE + CMD_W'(idx_q);
            K_BG:      command = CODE_BG;
            K_CLEAR:   command = CODE_CLEAR;
            K_WAIT:    command = CODE_WAIT;
            K_FINAL:   begin command = CODE_FINAL; choose = 2'b11; end
            K_STOP:    begin command = CODE_STOP;  choose = 2'b11; end
            default:   command = '0;
        endcase
    end

    assign step_start = first_q;
    assign frame_done = first_q && (kind_q == K_WAIT);

endmodule

// File: tb/tb_draw_sequencer_param.sv
// Bench for draw_sequencer_param: a timed instance and a handshaken instance
// (no judgement lines) against a code-arithmetic reference model.
module tb_draw_sequencer_param;

    localparam int TITLE = 20, LANE = 4, LINE = 3, SCORE = 5, BGC = 7, CLR = 2;

    logic CLK = 1'b0;
    logic reset = 1'b0, cont = 1'b0, pause = 1'b0, frame_sync = 1'b0;
    logic game_over = 1'b0, draw_done = 1'b0;

    logic [3:0] cmd0, cmd1;
    logic [1:0] ch0, ch1;
    logic ss0, ss1, fd0, fd1, bz0, bz1;

    always #5 CLK = ~CLK;

    draw_sequencer_param #(
        .CMD_W(4), .N_LANES(3), .N_LINES(2), .N_SCORE(1), .TITLE_CNT(TITLE),
        .LANE_CNT(LANE), .LINE_CNT(LINE), .SCORE_CNT(SCORE), .BG_CNT(BGC),
        .CLEAR_CNT(CLR), .HANDSHAKE(0)
    ) u0 (
        .CLK(CLK), .reset(reset), .continue_game(cont), .pause(pause),
        .frame_sync(frame_sync), .game_over(game_over), .draw_done(draw_done),
        .command(cmd0), .choose(ch0), .step_start(ss0), .frame_done(fd0), .busy(bz0)
    );

    draw_sequencer_param #(
        .CMD_W(4), .N_LANES(3), .N_LINES(0), .N_SCORE(1), .TITLE_CNT(TITLE),
        .LANE_CNT(LANE), .LINE_CNT(LINE), .SCORE_CNT(SCORE), .BG_CNT(BGC),
        .CLEAR_CNT(CLR), .HANDSHAKE(1)
    ) u1 (
        .CLK(CLK), .reset(reset), .continue_game(cont), .pause(pause),
        .frame_sync(frame_sync), .game_over(game_over), .draw_done(draw_done),
        .command(cmd1), .choose(ch1), .step_start(ss1), .frame_done(fd1), .busy(bz1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Frame jobs occupy consecutive codes 2..CLEAR, so a frame is "code+1 until CLEAR".
    int m_code[2], m_el[2];
    bit m_go[2], m_first[2];
    bit mvalid = 1'b0;
    logic [8:0] exp_q0[$], exp_q1[$];

    function automatic int n_lines(int p); return (p == 0) ? 2 : 0; endfunction
    function automatic int bg_code(int p); return 2 + 3 + n_lines(p) + 1; endfunction
    function automatic bit hs(int p); return p == 1; endfunction

    function automatic int dur(int p, int code);
        if (code < 5)              return LANE;
        if (code < 5 + n_lines(p)) return LINE;
        if (code < bg_code(p))     return SCORE;
        if (code == bg_code(p))    return BGC;
        if (code == bg_code(p)+1)  return CLR;
        return BGC;
    endfunction

    task automatic step_model(input int p);
        int old, nc, clr, fin, stp, wt;
        bit ended, go_eff;
        if (!reset) begin
            m_code[p] = 0; m_el[p] = 0; m_go[p] = 1'b0; m_first[p] = 1'b1;
            return;
        end
        old = m_code[p]; nc = old;
        clr = bg_code(p) + 1; fin = clr + 1; stp = clr + 2; wt = clr + 3;
        go_eff = m_go[p] || game_over;
        if (old < 2) begin
            if (cont) nc = 2;
            else if (m_el[p] == TITLE - 1) nc = old ^ 1;
        end else if (old <= clr || old == fin) begin
            ended = hs(p) ? (draw_done && m_el[p] != 0) : (m_el[p] == dur(p, old) - 1);
            if (ended) nc = (old == clr) ? (go_eff ? fin : wt) : (old == fin) ? stp : old + 1;
        end else if (old == wt) begin
            if (go_eff) nc = fin;
            else if (frame_sync && !pause) nc = 2;
        end
        if (old >= 2 && game_over) m_go[p] = 1'b1;
        m_first[p] = (nc != old);
        m_el[p]    = m_first[p] ? 0 : m_el[p] + 1;
        m_code[p]  = nc;
    endtask

    function automatic logic [8:0] expv(int p);
        int c, fin, wt;
        logic [1:0] chs;
        bit bz;
        c = m_code[p]; fin = bg_code(p) + 2; wt = bg_code(p) + 4;
        chs = (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : (c == fin || c == fin + 1) ? 2'b11 : 2'b10;
        bz  = (c >= 2 && c <= fin);
        return {4'(c), chs, m_first[p], m_first[p] && (c == wt), bz};
    endfunction

    always @(posedge CLK) begin
        step_model(0);
        step_model(1);
        if (!reset) mvalid = 1'b1;
        if (mvalid) begin
            exp_q0.push_back(expv(0));
            exp_q1.push_back(expv(1));
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge CLK) begin
        logic [8:0] e;
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            n_checks++;
            if ({cmd0, ch0, ss0, fd0, bz0} == e) n_pass++;
            else $display("FAIL dut0_outputs: got %h expected %h at %0t",
                          {cmd0, ch0, ss0, fd0, bz0}, e, $time);
        end
        while (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            n_checks++;
            if ({cmd1, ch1, ss1, fd1, bz1} == e) n_pass++;
            else $display("FAIL dut1_outputs: got %h expected %h at %0t",
                          {cmd1, ch1, ss1, fd1, bz1}, e, $time);
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    initial begin
        @(negedge CLK);
        tick(3);
        check("reset_cmd", cmd0, 0);
        check("reset_choose", ch0, 0);
        check("reset_busy", bz0, 0);
        check("reset_frame_done", fd0, 0);
        check("reset_step_start", ss0, 1);
        check("model_reset_cmd", m_code[0], 0);
        reset = 1'b1;

        tick(19);
        check("title_a_hold", cmd0, 0);
        tick(1);
        check("title_b_cmd", cmd0, 1);
        check("title_b_choose", ch0, 1);
        check("title_b_step_start", ss0, 1);
        check("model_title_b", m_code[0], 1);
        tick(19);
        check("title_b_hold", cmd1, 1);
        tick(1);
        check("title_a_again", cmd0, 0);

        tick(5);
        cont = 1'b1; tick(1); cont = 1'b0;
        check("continue_cmd", cmd0, 2);
        check("continue_cmd_hs", cmd1, 2);
        check("continue_busy", bz0, 1);
        tick(3);
        check("lane0_hold", cmd0, 2);
        tick(1);
        check("lane1_cmd", cmd0, 3);
        tick(28);
        check("wait_cmd", cmd0, 12);
        check("wait_frame_done", fd0, 1);
        check("model_wait", m_code[0], 12);
        tick(1);
        check("wait_frame_done_clear", fd0, 0);

        pause = 1'b1; frame_sync = 1'b1;
        tick(5);
        check("pause_hold", cmd0, 12);
        pause = 1'b0;
        tick(1);
        check("sync_restart", cmd0, 2);
        frame_sync = 1'b0;

        tick(4);
        game_over = 1'b1; tick(1); game_over = 1'b0;
        tick(27);
        check("final_cmd", cmd0, 10);
        check("final_choose", ch0, 3);
        check("final_busy", bz0, 1);
        tick(6);
        check("final_hold", cmd0, 10);
        tick(1);
        check("stop_cmd", cmd0, 11);
        check("stop_step_start", ss0, 1);
        cont = 1'b1; frame_sync = 1'b1;
        tick(40);
        check("stop_hold", cmd0, 11);
        cont = 1'b0; frame_sync = 1'b0;

        reset = 1'b0; tick(1); reset = 1'b1;
        cont = 1'b1; tick(1); cont = 1'b0;
        game_over = 1'b1; tick(1); game_over = 1'b0;
        tick(22);
        check("bg_cmd", cmd0, 8);
        tick(2);
        reset = 1'b0; tick(1); reset = 1'b1;
        check("mid_reset_cmd", cmd0, 0);
        check("mid_reset_choose", ch0, 0);
        check("mid_reset_busy", bz0, 0);
        cont = 1'b1; tick(1); cont = 1'b0;
        tick(32);
        check("after_reset_wait", cmd0, 12);
        check("after_reset_frame_done", fd0, 1);

        reset = 1'b0; tick(1); reset = 1'b1;
        cont = 1'b1; tick(1); cont = 1'b0;
        draw_done = 1'b1; tick(1);
        check("hs_first_cycle_ignored", cmd1, 2);
        draw_done = 1'b0; tick(1);
        check("hs_lane0_hold", cmd1, 2);
        draw_done = 1'b1; tick(1);
        check("hs_lane1_cmd", cmd1, 3);
        check("hs_lane1_step_start", ss1, 1);
        check("model_hs_lane1", m_code[1], 3);
        draw_done = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            reset      = ($urandom_range(0, 299) != 0);
            cont       = ($urandom_range(0, 39) == 0);
            game_over  = ($urandom_range(0, 599) == 0);
            frame_sync = ($urandom_range(0, 9) == 0);
            pause      = ($urandom_range(0, 2) == 0);
            draw_done  = ($urandom_range(0, 2) == 0);
            tick(1);
        end
        reset = 1'b1; cont = 1'b0; game_over = 1'b0; frame_sync = 1'b0;
        pause = 1'b0; draw_done = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_sequencer_param.md
# draw_sequencer_param

Parametrised successor to the game's fixed draw-command sequencer. It steps the VGA drawing engine through the title screen, then through a per-frame list of drawing jobs: lanes, judgement lines, score digits, background and play-area clear. Each job issues one `command` code for a counted or handshaken duration. Unlike the fixed sequencer, it adds:
- configurable lane, line and score-digit counts;
- an optional `draw_done` handshake;
- frame synchronisation with pause;
- a game-over path.

## Interface
- `CMD_W`, 5: width of `command`. Must be ≥ clog2(N_LANES+N_LINES+N_SCORE+7).
- `N_LANES`, 15: lane-block draw steps per frame (≥1).
- `N_LINES`, 3: judgement-line steps per frame (≥0).
- `N_SCORE`, 2: score-digit steps per frame (≥0).
- `TITLE_CNT`, 19201: cycles per title image.
- `LANE_CNT`, 32; `LINE_CNT`, 32; `SCORE_CNT`, 300; `BG_CNT`, 19201; `CLEAR_CNT`, 160: cycles per step. All ≥1.
- `HANDSHAKE`, 0: 0 = steps are timed; 1 = drawing steps end on `draw_done`.

Ports:
- `CLK` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low.
- `continue` in 1: leave the title screen.
- `pause` in 1: hold between frames.
- `frame_sync` in 1: start-of-frame strobe.
- `game_over` in 1: end the game.
- `draw_done` in 1: drawing engine finished the current job (HANDSHAKE=1 only).
- `command` out CMD_W: current draw job code.
- `choose` out 2: palette/image select.
- `step_start` out 1: first cycle of every step.
- `frame_done` out 1: one-cycle pulse on entering WAIT_SYNC.
- `busy` out 1: a drawing job is in progress.

## Operation
- States:
  - TITLE_A, TITLE_B: title screens.
  - LANE[i], i = 0..N_LANES-1.
  - LINE[j], j = 0..N_LINES-1.
  - SCORE[k], k = 0..N_SCORE-1.
  - BACKGROUND, PLAY_CLEAR, WAIT_SYNC, FINAL, STOP.
- `command` codes, using L=N_LANES, N=N_LINES, S=N_SCORE:
  - TITLE_A = 0, TITLE_B = 1.
  - LANE[i] = 2+i.
  - LINE[j] = 2+L+j.
  - SCORE[k] = 2+L+N+k.
  - BACKGROUND = 2+L+N+S, PLAY_CLEAR = 3+L+N+S, FINAL = 4+L+N+S, STOP = 5+L+N+S, WAIT_SYNC = 6+L+N+S.
  - With default parameters: lanes 2–16, lines 17–19, score 20–21, BACKGROUND 22, PLAY_CLEAR 23, FINAL 24, STOP 25, WAIT_SYNC 26.
- `choose`: 00 in TITLE_A; 01 in TITLE_B; 11 in FINAL and STOP; 10 in all other states.
- `busy` is 1 in LANE, LINE, SCORE, BACKGROUND, PLAY_CLEAR and FINAL; 0 elsewhere.
- Title phase:
  - TITLE_A and TITLE_B alternate every TITLE_CNT cycles.
  - `continue`=1 in either title state moves to LANE[0] at the next edge; this overrides the swap.
  - `pause`, `frame_sync`, `game_over` and `draw_done` are ignored during the title phase.
- Frame order: LANE[0..L-1] → LINE[0..N-1] → SCORE[0..S-1] → BACKGROUND → PLAY_CLEAR → WAIT_SYNC → LANE[0]. Groups with zero steps are skipped.
- Step duration, HANDSHAKE=0: a step occupies exactly its parameter count of cycles. The step counter runs 0..CNT-1 and the state advances at the edge where the counter equals CNT-1.
- Step duration, HANDSHAKE=1:
  - All drawing steps (`busy`=1) end at the edge where `draw_done`=1 is sampled, except in the step's first cycle, where `draw_done` is ignored. Minimum step length is therefore 2 cycles.
  - The counter is unused in drawing steps; title timing is still counted.
- WAIT_SYNC: advances to LANE[0] at the edge where `frame_sync`=1 and `pause`=0. While `pause`=1 it stays put regardless of `frame_sync`.
- Game over:
  - `game_over`=1 is latched into a sticky flag in any non-title state. The flag is cleared only by reset.
  - With the flag set, PLAY_CLEAR completion goes to FINAL instead of WAIT_SYNC, so the current frame finishes normally.
  - If the flag sets while in WAIT_SYNC, the next state is FINAL.
  - FINAL lasts BG_CNT cycles (or ends on `draw_done` when HANDSHAKE=1), then goes to STOP.
  - STOP is held until reset; all inputs are ignored there.
- Simultaneous `game_over` and `frame_sync` in WAIT_SYNC: FINAL wins.

## Timing
- Reset: `reset`=0 at any edge, including mid-step, forces at that edge:
  - state TITLE_A, counters and indices 0, game-over flag cleared;
  - `command`=0, `choose`=00, `busy`=0, `frame_done`=0;
  - `step_start`=1 in the first cycle after `reset` returns high.
- `command`, `choose` and `busy` are decoded from registered state. They change in the same cycle as the state, with no extra latency.
- `step_start` is 1 in the first cycle of each step, including each title swap and each LANE/LINE/SCORE index. It is also 1 on entry to WAIT_SYNC and STOP.
- `frame_done` is 1 only in the first cycle of WAIT_SYNC.
- `continue` sampled high at edge k: `command`=2 from edge k onward.
- Frame length, HANDSHAKE=0: L·LANE_CNT + N·LINE_CNT + S·SCORE_CNT + BG_CNT + CLEAR_CNT cycles, plus WAIT_SYNC dwell. With default parameters that is 480+96+600+19201+160 = 20537 cycles.

## Test plan
- Reset low 3 cycles, then release → `command`=0, `choose`=00 for 19201 cycles; then `command`=1, `choose`=01 for 19201 cycles; then `command`=0 again; `step_start` pulses at each swap.
- `continue` pulse during TITLE_B → `command` 2..16 at 32 cycles each, 17..19 at 32 each, 20..21 at 300 each, 22 for 19201, 23 for 160, then 26 with a single `frame_done` pulse. A `frame_sync` pulse then gives `command`=2 at the next edge.
- In WAIT_SYNC with `pause`=1, pulse `frame_sync` 5 times → stays at `command`=26. Drop `pause` while `frame_sync`=1 → `command`=2 next cycle.
- `game_over` pulse during LANE[5] → frame completes through `command`=23, then `command`=24 with `choose`=11 for 19201 cycles, then `command`=25 held for 10000 cycles; `continue` and `frame_sync` are ignored.
- HANDSHAKE=1: `draw_done` high in LANE[0]'s first cycle → ignored. `draw_done` high in the 3rd cycle → LANE[0] lasts 3 cycles and `command`=3 follows.
- `reset` low for 1 cycle during BACKGROUND with the game-over flag set → TITLE_A with `command`=0, `choose`=00. `continue` then gives a normal frame ending in WAIT_SYNC, not FINAL.
